// File: rtl/imm_gen_pipe.sv
// Immediate generator for the RV32/RV64+V decode stage.
// Registered valid/ready output with a one-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter bit ENABLE_VEC = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_imm2,
    output logic [3:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [3:0] F_NONE = 4'd0;
    localparam logic [3:0] F_I    = 4'd1;
    localparam logic [3:0] F_S    = 4'd2;
    localparam logic [3:0] F_B    = 4'd3;
    localparam logic [3:0] F_U    = 4'd4;
    localparam logic [3:0] F_J    = 4'd5;
    localparam logic [3:0] F_Z    = 4'd6;
    localparam logic [3:0] F_VS5  = 4'd7;
    localparam logic [3:0] F_VZ11 = 4'd8;
    localparam logic [3:0] F_VZ10 = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] imm2;
        logic [3:0]      fmt;
        logic            illegal;
    } res_t;

    logic [31:0] w;
    logic [31:0] imm32;
    logic [31:0] imm2_32;
    logic [3:0]  fmt;
    logic        illegal;
    res_t        dec;

    assign w = in_instr;

    always_comb begin
        imm32   = '0;
        imm2_32 = '0;
        fmt     = F_NONE;
        illegal = 1'b0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                fmt   = F_I;
                imm32 = {{20{w[31]}}, w[31:20]};
            end
            7'b0100011: begin
                fmt   = F_S;
                imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'b1100011: begin
                fmt   = F_B;
                imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt   = F_U;
                imm32 = {w[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt   = F_J;
                imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'b1110011: begin
                fmt   = F_Z;
                imm32 = {27'b0, w[19:15]};
            end
            7'b0000111, 7'b0100111: begin
                fmt = F_NONE;
            end
            7'b1010111: begin
                if (!ENABLE_VEC) begin
                    illegal = 1'b1;
                end else if (w[14:12] == 3'b011) begin
                    fmt   = F_VS5;
                    imm32 = {{27{w[19]}}, w[19:15]};
                end else if (w[14:12] == 3'b111 && !w[31]) begin
                    fmt   = F_VZ11;
                    imm32 = {21'b0, w[30:20]};
                end else if (w[14:12] == 3'b111 && w[30]) begin
                    fmt     = F_VZ10;
                    imm32   = {22'b0, w[29:20]};
                    imm2_32 = {27'b0, w[19:15]};
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // zero-extended fields never reach bit 31, so one sign-extend covers all
    always_comb begin
        dec.imm     = XLEN'($signed(imm32));
        dec.imm2    = XLEN'(imm2_32);
        dec.fmt     = fmt;
        dec.illegal = illegal;
    end

    res_t main_q, skid_q;
    logic main_valid, skid_valid;
    logic main_vn, skid_vn;
    logic ld_main_in, ld_main_skid, ld_skid;
    logic accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    always_comb begin
        main_vn      = main_valid;
        skid_vn      = skid_valid;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            main_vn = 1'b0;
            skid_vn = 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                ld_main_skid = 1'b1;
                skid_vn      = 1'b0;
            end else if (accept) begin
                ld_main_in = 1'b1;
            end else begin
                main_vn = 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                ld_skid = 1'b1;
                skid_vn = 1'b1;
            end else begin
                ld_main_in = 1'b1;
                main_vn    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_vn;
            skid_valid <= skid_vn;
            in_ready   <= ~skid_vn;
            if (ld_main_in)   main_q <= dec;
            if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)      skid_q <= dec;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_imm2    = main_q.imm2;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32+V instance and an RV64 instance
// without vector support, both fed the same stimulus.
module tb_imm_gen_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_imm2;
    logic [3:0]  out_fmt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_imm2;
    logic [3:0]  b_out_fmt;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] imm2;
        logic [3:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    imm_gen_pipe #(.XLEN(32), .ENABLE_VEC(1'b1)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_imm2(out_imm2),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .ENABLE_VEC(1'b0)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_imm2(b_out_imm2),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
    );

    always #5 clock = ~clock;

    function automatic longint u(input logic [31:0] x);
        return longint'({32'b0, x});
    endfunction

    // Immediate value as a mathematical integer, then truncated per XLEN
    function automatic exp_t model(input logic [31:0] w, input bit vec);
        exp_t   e;
        longint v = 0;
        longint v2 = 0;
        longint sgn = w[31] ? -1 : 0;
        int     fmt = 0;
        bit     ill = 1'b0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                fmt = 1; v = u(w[31:20]) + sgn * 4096;
            end
            7'b0100011: begin
                fmt = 2; v = u({w[31:25], w[11:7]}) + sgn * 4096;
            end
            7'b1100011: begin
                fmt = 3;
                v = sgn * 4096 + u(w[7]) * 2048 + u(w[30:25]) * 32 + u(w[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                fmt = 4; v = u(w[31:12]) * 4096 + sgn * 64'sd4294967296;
            end
            7'b1101111: begin
                fmt = 5;
                v = sgn * 1048576 + u(w[19:12]) * 4096 + u(w[20]) * 2048 + u(w[30:21]) * 2;
            end
            7'b1110011: begin
                fmt = 6; v = u(w[19:15]);
            end
            7'b0000111, 7'b0100111: fmt = 0;
            7'b1010111: begin
                if (!vec) ill = 1'b1;
                else if (w[14:12] == 3'b011) begin
                    fmt = 7; v = u(w[19:15]) - (w[19] ? 32 : 0);
                end else if (w[14:12] == 3'b111 && w[31] == 1'b0) begin
                    fmt = 8; v = u(w[30:20]);
                end else if (w[14:12] == 3'b111 && w[30] == 1'b1) begin
                    fmt = 9; v = u(w[29:20]); v2 = u(w[19:15]);
                end
            end
            default: ill = 1'b1;
        endcase
        e.imm = v;
        e.imm2 = v2;
        e.fmt = fmt[3:0];
        e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [14];
        logic [31:0] w;
        int          k;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0000111,
                7'b0100111, 7'b1010111, 7'b1010111, 7'b1010111};
        w = $urandom;
        k = $urandom_range(0, 14);
        if (k < 14) w[6:0] = ops[k];
        if (w[6:0] == 7'b1010111 && $urandom_range(0, 3) != 0)
            w[14:12] = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b011;
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_chk++;
        if ({out_valid, in_ready, out_imm, out_imm2, out_fmt, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b rdy=%b imm=%h imm2=%h fmt=%0d ill=%b, need all 0",
                     out_valid, in_ready, out_imm, out_imm2, out_fmt, out_illegal);
        end
        reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b v=%b, need rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 4'd1
            || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL addi: v=%b imm=%h fmt=%0d ill=%b, need 1 ffffffff 1 0",
                     out_valid, out_imm, out_fmt, out_illegal);
        end
        n_chk++;
        if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF || b_out_fmt !== 4'd1) begin
            n_fail++;
            $display("FAIL addi64: imm=%h fmt=%0d, need ffffffffffffffff 1", b_out_imm, b_out_fmt);
        end
        @(negedge clock);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_drain: v=%b, need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = 32'hFE000EE3; out_ready = 1'b1;
        @(negedge clock);
        in_instr = 32'h022EB0D7;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_fmt !== 4'd3) begin
            n_fail++;
            $display("FAIL b2b_beq: v=%b imm=%h fmt=%0d, need 1 fffffffc 3", out_valid, out_imm, out_fmt);
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFD || out_fmt !== 4'd7) begin
            n_fail++;
            $display("FAIL b2b_vadd: v=%b imm=%h fmt=%0d, need 1 fffffffd 7", out_valid, out_imm, out_fmt);
        end
        n_chk++;
        if (b_out_illegal !== 1'b1 || b_out_imm !== 64'd0 || b_out_fmt !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_vadd_novec: ill=%b imm=%h fmt=%0d, need 1 0 0", b_out_illegal, b_out_imm, b_out_fmt);
        end
        @(negedge clock);
    endtask

    task automatic test_vsetvli();
        in_valid = 1'b1; in_instr = 32'h01007057; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'h10 || out_fmt !== 4'd8
            || out_imm2 !== 32'h0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL vsetvli: v=%b imm=%h fmt=%0d imm2=%h ill=%b, need 1 10 8 0 0",
                     out_valid, out_imm, out_fmt, out_imm2, out_illegal);
        end
        n_chk++;
        if (b_out_illegal !== 1'b1 || b_out_imm !== 64'd0) begin
            n_fail++;
            $display("FAIL vsetvli_novec: ill=%b imm=%h, need 1 0", b_out_illegal, b_out_imm);
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        @(negedge clock);
        in_instr = 32'h00200093;
        @(negedge clock);
        in_instr = 32'h00300093;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_drop: rdy=%b, need 0", in_ready);
        end
        repeat (2) @(negedge clock);
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b v=%b imm=%h, need 0 1 1", in_ready, out_valid, out_imm);
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: v=%b imm=%h rdy=%b, need 1 2 1", out_valid, out_imm, in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_third: v=%b imm=%h, need 1 3", out_valid, out_imm);
        end
        @(negedge clock);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: v=%b, need 0 (duplicate output)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        @(negedge clock);
        in_instr = 32'h00200093;
        @(negedge clock);
        flush = 1'b1; in_instr = 32'h12300093;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: v=%b rdy=%b, need 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_instr = 32'h00400093;
        @(negedge clock);
        flush = 1'b1; in_instr = 32'h12300093;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drop_input: v=%b rdy=%b imm=%h, need 0 1", out_valid, in_ready, out_imm);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        @(negedge clock);
        in_instr = 32'h00600093;
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, in_ready, out_imm, out_imm2, out_fmt, out_illegal} !== '0
            || b_out_imm !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_async: v=%b rdy=%b imm=%h fmt=%0d, need all 0",
                     out_valid, in_ready, out_imm, out_fmt);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: rdy=%b v=%b, need 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1; in_instr = 32'h80000037; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_imm !== 32'h80000000 || out_fmt !== 4'd4
            || b_out_imm !== 64'hFFFFFFFF80000000) begin
            n_fail++;
            $display("FAIL reset_mid_first: v=%b imm=%h fmt=%0d imm64=%h, need 1 80000000 4 ffffffff80000000",
                     out_valid, out_imm, out_fmt, b_out_imm);
        end
        @(negedge clock);
    endtask

    task automatic test_random(input int n);
        exp_t ea, eb;
        int   sz;
        bit   acc, drn;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clock);
        qa.delete(); qb.delete();
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            #1;
            sz = qa.size();
            n_chk++;
            if (out_valid !== (sz != 0) || in_ready !== (sz < 2)
                || b_out_valid !== (sz != 0) || b_in_ready !== (sz < 2)) begin
                n_fail++;
                $display("FAIL rnd_hs[%0d]: v=%b rdy=%b bv=%b brdy=%b, need v=%b rdy=%b",
                         i, out_valid, in_ready, b_out_valid, b_in_ready, sz != 0, sz < 2);
            end
            if (sz != 0) begin
                ea = qa[0];
                eb = qb[0];
                n_chk++;
                if (out_imm !== ea.imm[31:0] || out_imm2 !== ea.imm2[31:0]
                    || out_fmt !== ea.fmt || out_illegal !== ea.ill) begin
                    n_fail++;
                    $display("FAIL rnd_data32[%0d]: imm=%h imm2=%h fmt=%0d ill=%b, need %h %h %0d %b",
                             i, out_imm, out_imm2, out_fmt, out_illegal,
                             ea.imm[31:0], ea.imm2[31:0], ea.fmt, ea.ill);
                end
                n_chk++;
                if (b_out_imm !== eb.imm || b_out_imm2 !== eb.imm2
                    || b_out_fmt !== eb.fmt || b_out_illegal !== eb.ill) begin
                    n_fail++;
                    $display("FAIL rnd_data64[%0d]: imm=%h imm2=%h fmt=%0d ill=%b, need %h %h %0d %b",
                             i, b_out_imm, b_out_imm2, b_out_fmt, b_out_illegal,
                             eb.imm, eb.imm2, eb.fmt, eb.ill);
                end
            end
            acc = in_valid && (sz < 2);
            drn = out_ready && (sz != 0);
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                if (drn) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
                if (acc) begin
                    qa.push_back(model(in_instr, 1'b1));
                    qb.push_back(model(in_instr, 1'b0));
                end
            end
            @(negedge clock);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_vsetvli();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the RV32/RV64 core with the vector extension.
- Takes a raw instruction word from fetch and extracts the immediate directly; no pre-extracted immediates are required.
- Decodes all base-ISA formats, CSR zimm, and the OP-V immediates (OPIVI simm5, vsetvli zimm11, vsetivli zimm10/uimm5).
- Presents the result through a registered valid/ready stage with a 2-entry skid buffer, flush support and an illegal-opcode flag.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- ENABLE_VEC, 1, 1 = decode OP-V immediates; 0 = OP-V is reported illegal.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the block can accept an instruction.
- in_instr  in  32  raw instruction word.
- flush  in  1  discard all held entries and any same-cycle input.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_imm  out  XLEN  primary immediate.
- out_imm2  out  XLEN  secondary immediate: vsetivli uimm5 (AVL) zero-extended; 0 otherwise.
- out_fmt  out  4  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 VSIMM5, 8 VZIMM11, 9 VZIMM10.
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Opcode to format mapping:
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - LUI 0110111, AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - SYSTEM 1110011 -> Z: instr[19:15] zero-extended.
  - LOAD-FP 0000111, STORE-FP 0100111 -> NONE, imm 0, legal.
  - OP-V 1010111, decoded by funct3:
    - funct3=011 -> VSIMM5: instr[19:15] sign-extended.
    - funct3=111 with instr[31]=0 -> VZIMM11: instr[30:20] zero-extended.
    - funct3=111 with instr[31:30]=11 -> VZIMM10: instr[29:20] zero-extended; out_imm2 = instr[19:15] zero-extended.
    - funct3=111 with instr[31:30]=10 (vsetvl) -> NONE.
    - any other funct3 -> NONE.
  - Any other opcode -> fmt NONE, imm 0, imm2 0, illegal=1.
  - With ENABLE_VEC=0, OP-V is treated as an unrecognised opcode.
- Extension rules:
  - I, S, B, J and VSIMM5 are sign-extended from their top immediate bit to XLEN.
  - U is instr[31:12]<<12, sign-extended from bit 31 when XLEN=64.
  - B and J have bit 0 = 0.
- Latency: exactly 1 cycle from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+1, when the buffer is empty.
- Storage: a main output register plus one skid register.
  - in_ready = ~skid_valid, registered; no combinational path from out_ready to in_ready.
  - Output drains when out_valid & out_ready. The skid entry moves to main in the same cycle.
  - Simultaneous accept and drain keeps full throughput: 1 instruction/cycle with out_ready held high.
  - Order is strictly FIFO. Outputs hold stable while out_valid=1 and out_ready=0.
- Flush (synchronous):
  - Next edge clears main_valid and skid_valid.
  - A same-cycle in_valid is dropped.
  - in_ready=1 in the following cycle.
  - Flush has priority over accept and drain.
- Reset asserted (asynchronous):
  - out_valid=0, in_ready=0, out_imm=0, out_imm2=0, out_fmt=0, out_illegal=0; skid cleared.
  - in_ready becomes 1 on the first edge after deassertion.
  - Reset mid-stream discards all entries with no partial outputs.
- Data registers load only on an accept, so there is no toggling on idle cycles.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0; with XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
- BEQ offset -4 (0xFE000EE3) then vadd.vi v1,v2,-3 (0x022EB0D7) back-to-back:
  - First result: imm=0xFFFFFFFC, fmt=3.
  - Second result: imm=0xFFFFFFFD, fmt=7.
  - One result per cycle.
- vsetvli x0,x0,e32,m1 (0x01007057) -> imm=0x10, fmt=8, imm2=0. Same word with ENABLE_VEC=0 -> illegal=1, imm=0.
- out_ready=0 for 4 cycles while 3 instructions are offered:
  - in_ready drops after 2 accepts; the 3rd is held at the input.
  - On release, outputs appear in order with no loss or duplication.
- With buffer full, assert flush plus in_valid -> next cycle out_valid=0 and in_ready=1; the offered word never appears.
- Assert reset mid-stream with 2 entries held -> all outputs 0 immediately (asynchronous); after release, in_ready=1 within 1 edge and the first new instruction emerges after 1 cycle.
